key_input: RTL and testbench

- Button input front end for the numeric code detonator on PYNQ-Z2. It is the input-side counterpart of the LED output drivers.
- Synchronises and debounces the raw push-buttons and detects press edges.
- Delivers one key event at a time to the code-entry controller over a valid/ready handshake.
- Sits between the board button pins and the detonator control FSM.

---
 rtl/key_input.sv | 160 ++++++++++++++++
 tb/tb_key_input.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input.sv
// Push-button front end: two-flop sync, per-key debounce, press detect and a
// one-entry valid/ready event register. Optional long-press events: LONG_PRESS_EN.
module key_input #(
    parameter int NUM_KEYS         = 4,
    parameter int DEBOUNCE_CNT_MAX = 2_500_000,
    parameter int LONG_CNT_MAX     = 125_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [1:0]          key_code,
    output logic                key_long,
    output logic                key_overflow
);

    localparam int          NUM_REQ = 2 * NUM_KEYS;
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CNT_MAX - 1);

    if (NUM_KEYS < 1 || NUM_KEYS > 4 || DEBOUNCE_CNT_MAX < 1 || LONG_CNT_MAX < 2) begin : g_param_check
        $error("key_input: parameter out of range");
    end

    logic [NUM_KEYS-1:0] s1_q, s2_q;
    logic [NUM_KEYS-1:0] level_q, level_d, prev_q;
    logic [31:0]         db_cnt_q [NUM_KEYS];
    logic [31:0]         db_cnt_d [NUM_KEYS];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        level_d = level_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_d[k] = '0;
            if (s2_q[k] != level_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    level_d[k] = s2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 32'd1;
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values, like real hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            prev_q  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
        end else begin
            s1_q     <= key_in;
            s2_q     <= s1_q;
            level_q  <= level_d;
            prev_q   <= level_q;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic [NUM_KEYS-1:0] rise_req, long_req;
    assign rise_req = level_q & ~prev_q;

`ifdef LONG_PRESS_EN
    // Hold counter saturates one past the fire value so each press fires once.
    localparam logic [31:0] HOLD_FIRE = 32'(LONG_CNT_MAX - 1);
    localparam logic [31:0] HOLD_SAT  = 32'(LONG_CNT_MAX);

    logic [31:0] hold_q [NUM_KEYS];
    logic [31:0] hold_d [NUM_KEYS];

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            hold_d[k]   = '0;
            long_req[k] = level_q[k] && (hold_q[k] == HOLD_FIRE);
            if (level_q[k]) begin
                hold_d[k] = (hold_q[k] == HOLD_SAT) ? hold_q[k] : hold_q[k] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_KEYS; k++) hold_q[k] <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign long_req = '0;
`endif

    logic [NUM_REQ-1:0] req_vec;
    logic [2:0]         sel_idx;
    logic               any_req, multi_req;

    // Request slot 2k is key k short, 2k+1 key k long; the lowest set slot wins.
    always_comb begin
        req_vec = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            req_vec[2*k]   = rise_req[k];
            req_vec[2*k+1] = long_req[k];
        end
        sel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vec[i]) sel_idx = 3'(i);
        end
    end

    assign any_req   = |req_vec;
    assign multi_req = |(req_vec & (req_vec - NUM_REQ'(1)));

    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic       long_q, long_d;
    logic       ovf_q, ovf_d;
    logic       accept;

    assign accept = !valid_q || key_ready;

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        long_d  = long_q;
        ovf_d   = 1'b0;
        if (any_req && accept) begin
            valid_d = 1'b1;
            code_d  = sel_idx[2:1];
            long_d  = sel_idx[0];
            ovf_d   = multi_req;
        end else if (any_req) begin
            ovf_d = 1'b1;
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            long_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            long_q  <= long_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_level    = level_q;
    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign key_long     = long_q;
    assign key_overflow = ovf_q;

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed scenarios plus a randomized run
// compared against a behavioural model of debounce, press events and handshake.
module tb_key_input;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int LG = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;
    logic          key_valid;
    logic          key_ready;
    logic [1:0]    key_code;
    logic          key_long;
    logic          key_overflow;

    int n_pass  = 0;
    int n_total = 0;

    key_input #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CNT_MAX(DB),
        .LONG_CNT_MAX    (LG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_long    (key_long),
        .key_overflow(key_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last DB synchronised samples all
    // disagree with it; events come from how long each key has been held.
    logic [NK-1:0] m_d1, m_d2, m_level;
    bit   [DB-1:0] m_hist [NK];
    int            m_high [NK];
    logic          m_valid, m_long, m_ovf;
    logic [1:0]    m_code;
    int            m_nreq, m_first;
    bit            m_first_long, m_acc, m_s2;

    always @(posedge clk) begin
        if (!rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0;
            for (int k = 0; k < NK; k++) begin m_hist[k] = '0; m_high[k] = 0; end
            m_valid = 1'b0; m_long = 1'b0; m_ovf = 1'b0; m_code = '0;
        end else begin
            m_nreq = 0; m_first = -1; m_first_long = 1'b0;
            for (int k = 0; k < NK; k++) begin
                if (m_high[k] == 1) begin
                    if (m_first < 0) begin m_first = k; m_first_long = 1'b0; end
                    m_nreq++;
                end
`ifdef LONG_PRESS_EN
                if (m_high[k] == LG) begin
                    if (m_first < 0) begin m_first = k; m_first_long = 1'b1; end
                    m_nreq++;
                end
`endif
            end
            m_acc = !m_valid || key_ready;
            m_ovf = 1'b0;
            if (m_nreq > 0 && m_acc) begin
                m_valid = 1'b1; m_code = 2'(m_first); m_long = m_first_long; m_ovf = (m_nreq > 1);
            end else if (m_nreq > 0) begin
                m_ovf = 1'b1;
            end else if (m_valid && key_ready) begin
                m_valid = 1'b0;
            end
            for (int k = 0; k < NK; k++) begin
                m_s2 = m_d2[k]; m_d2[k] = m_d1[k]; m_d1[k] = key_in[k];
                m_hist[k] = {m_hist[k][DB-2:0], m_s2};
                if (m_hist[k] == {DB{~m_level[k]}}) m_level[k] = ~m_level[k];
                if (!m_level[k]) m_high[k] = 0;
                else if (m_high[k] <= LG) m_high[k] = m_high[k] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        key_in = '0; key_ready = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b0; key_in = 4'b0001; key_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            n_total++;
            if ({key_level, key_valid, key_code, key_long, key_overflow} !== 9'h0)
                $display("FAIL reset_outputs: got %h required 0", {key_level, key_valid, key_code, key_long, key_overflow});
            else n_pass++;
        end
        rst = 1'b1;
        tick(5);
        n_total++;
        if (key_level !== 4'b0000) $display("FAIL reset_level_early: got %b required 0000", key_level); else n_pass++;
        tick(1);
        n_total++;
        if (key_level !== 4'b0001 || key_valid !== 1'b0)
            $display("FAIL reset_level_rise: got level %b valid %b required 0001/0", key_level, key_valid);
        else n_pass++;
        tick(1);
        n_total++;
        if ({key_valid, key_code, key_long, key_overflow} !== 5'b1_00_0_0)
            $display("FAIL reset_event: got %b required 10000", {key_valid, key_code, key_long, key_overflow});
        else n_pass++;
        tick(1);
        n_total++;
        if (key_valid !== 1'b0) $display("FAIL reset_event_drop: got %b required 0", key_valid); else n_pass++;
        key_in = '0; bad = 1'b0;
        for (int c = 0; c < 10; c++) begin tick(1); if (key_valid) bad = 1'b1; end
        n_total++;
        if (bad !== 1'b0 || key_level !== 4'b0000)
            $display("FAIL release_no_event: got spurious %b level %b required 0/0000", bad, key_level);
        else n_pass++;
    endtask

    task automatic test_debounce();
        bit bad = 1'b0;
        key_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            key_in[2] = ((c % 4) < 2);
            tick(1);
            if (key_level !== 4'b0000) bad = 1'b1;
        end
        key_in[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin tick(1); if (key_level !== 4'b0000) bad = 1'b1; end
        n_total++;
        if (bad !== 1'b0) $display("FAIL debounce_bounce: level moved %b required 0", bad); else n_pass++;
        tick(1);
        n_total++;
        if (key_level !== 4'b0100) $display("FAIL debounce_accept: got %b required 0100", key_level); else n_pass++;
        tick(1);
        n_total++;
        if ({key_valid, key_code, key_long} !== 4'b1_10_0)
            $display("FAIL debounce_event: got %b required 1100", {key_valid, key_code, key_long});
        else n_pass++;
        settle();
    endtask

    task automatic test_overflow_hold();
        key_ready = 1'b0; key_in = 4'b0010;
        tick(7);
        n_total++;
        if ({key_valid, key_code} !== 3'b1_01) $display("FAIL hold_first: got %b required 101", {key_valid, key_code}); else n_pass++;
        key_in = 4'b1000;
        tick(6);
        n_total++;
        if ({key_valid, key_code, key_overflow} !== 4'b1_01_0)
            $display("FAIL hold_pre_ovf: got %b required 1010", {key_valid, key_code, key_overflow});
        else n_pass++;
        tick(1);
        n_total++;
        if ({key_valid, key_code, key_long, key_overflow} !== 5'b1_01_0_1)
            $display("FAIL hold_ovf: got %b required 10101", {key_valid, key_code, key_long, key_overflow});
        else n_pass++;
        key_ready = 1'b1;
        tick(1);
        n_total++;
        if ({key_valid, key_overflow} !== 2'b00)
            $display("FAIL hold_drain: got %b required 00", {key_valid, key_overflow});
        else n_pass++;
        settle();
    endtask

    task automatic test_simultaneous();
        bit bad = 1'b0;
        key_ready = 1'b1; key_in = 4'b1001;
        tick(7);
        n_total++;
        if ({key_valid, key_code, key_long, key_overflow} !== 5'b1_00_0_1)
            $display("FAIL simul_event: got %b required 10001", {key_valid, key_code, key_long, key_overflow});
        else n_pass++;
        for (int c = 0; c < 5; c++) begin tick(1); if (key_valid || key_overflow) bad = 1'b1; end
        n_total++;
        if (bad !== 1'b0) $display("FAIL simul_single: got extra activity %b required 0", bad); else n_pass++;
        settle();
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b1; key_in = 4'b0010;
        tick(1);
        key_in = 4'b0110;
        tick(6);
        n_total++;
        if ({key_valid, key_code} !== 3'b1_01) $display("FAIL b2b_first: got %b required 101", {key_valid, key_code}); else n_pass++;
        tick(1);
        n_total++;
        if ({key_valid, key_code, key_overflow} !== 4'b1_10_0)
            $display("FAIL b2b_second: got %b required 1100", {key_valid, key_code, key_overflow});
        else n_pass++;
        tick(1);
        n_total++;
        if (key_valid !== 1'b0) $display("FAIL b2b_drain: got %b required 0", key_valid); else n_pass++;
        settle();
    endtask

    task automatic test_long_press();
        int ev_c[$]; int ev_v[$]; int exp_n;
        key_ready = 1'b1; key_in = 4'b0010;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if (c == 40) key_in = '0;
            if (key_valid) begin ev_c.push_back(c); ev_v.push_back({key_code, key_long}); end
        end
`ifdef LONG_PRESS_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        n_total++;
        if (ev_c.size() !== exp_n) $display("FAIL long_count: got %0d required %0d", ev_c.size(), exp_n); else n_pass++;
        n_total++;
        if (ev_c.size() < 1 || ev_c[0] !== 7 || ev_v[0] !== 3'b01_0)
            $display("FAIL long_short_event: got %0d events first at %0d required cycle 7 code 1 long 0", ev_c.size(), (ev_c.size() > 0) ? ev_c[0] : -1);
        else n_pass++;
`ifdef LONG_PRESS_EN
        n_total++;
        if (ev_c.size() < 2 || ev_c[1] !== LG + 6 || ev_v[1] !== 3'b01_1)
            $display("FAIL long_event: got %0d events second at %0d required cycle %0d code 1 long 1", ev_c.size(), (ev_c.size() > 1) ? ev_c[1] : -1, LG + 6);
        else n_pass++;
`endif
        ev_c.delete(); ev_v.delete();
        key_in = 4'b0010;
        for (int c = 1; c <= 14; c++) begin
            tick(1);
            if (c == 8) key_in = '0;
            if (key_valid) begin ev_c.push_back(c); ev_v.push_back({key_code, key_long}); end
        end
        n_total++;
        if (ev_c.size() !== 1 || ev_c[0] !== 7 || ev_v[0] !== 3'b01_0)
            $display("FAIL repress_event: got %0d events required one at cycle 7 code 1 long 0", ev_c.size());
        else n_pass++;
        settle();
    endtask

    task automatic test_mid_reset();
        bit bad = 1'b0;
        key_ready = 1'b0; key_in = 4'b0001;
        tick(7);
        n_total++;
        if (key_valid !== 1'b1) $display("FAIL midrst_pending: got %b required 1", key_valid); else n_pass++;
        rst = 1'b0; key_in = '0;
        tick(1);
        n_total++;
        if ({key_level, key_valid, key_overflow} !== 6'h0)
            $display("FAIL midrst_clear: got %b required 000000", {key_level, key_valid, key_overflow});
        else n_pass++;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin tick(1); if (key_valid) bad = 1'b1; end
        n_total++;
        if (bad !== 1'b0) $display("FAIL midrst_stale: got stale valid %b required 0", bad); else n_pass++;
        settle();
    endtask

    task automatic test_random();
        int div;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick(1);
            n_total++;
            if ({key_level, key_valid, key_code, key_long, key_overflow} !== {m_level, m_valid, m_code, m_long, m_ovf})
                $display("FAIL random_cycle_%0d: got %b required %b", cyc,
                         {key_level, key_valid, key_code, key_long, key_overflow}, {m_level, m_valid, m_code, m_long, m_ovf});
            else n_pass++;
            rst = !(cyc == 1500 || cyc == 1501);
            case ((cyc / 500) % 3)
                0:       div = 3;
                1:       div = 12;
                default: div = 40;
            endcase
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, div - 1) == 0) key_in[k] = ~key_in[k];
            end
            key_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_overflow_hold();
        test_simultaneous();
        test_back_to_back();
        test_long_press();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
